// File: rtl/rec_pkg.sv
// Shared definitions for the audio recorder transport controller.
// State encoding and default sram address width.
package rec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2,
        PAUSE  = 2'd3
    } state_t;

    localparam int ADDR_W_DEF = 18;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// The pulse is one clk cycle wide per rising edge of d.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= d;
            s2    <= s1;
            s3    <= s2;
            pulse <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/rec_ctrl.sv
// Recorder transport FSM: record/play/pause control, shared sample
// address counter, recording length and lrc-paced memory strobes.
module rec_ctrl
    import rec_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_btn,
    input  logic              record_btn,
    input  logic              lrc,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W:0]   length,
    output logic              record,
    output logic              play,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic              full,
    output logic [1:0]        state
);

    state_t          st;
    logic            play_p;
    logic            rec_p;
    logic            tick;
    logic [ADDR_W:0] addr_nx;

    sync_edge u_play (
        .clk   (clk),
        .rst_n (reset),
        .d     (play_btn),
        .pulse (play_p)
    );

    sync_edge u_rec (
        .clk   (clk),
        .rst_n (reset),
        .d     (record_btn),
        .pulse (rec_p)
    );

    sync_edge u_lrc (
        .clk   (clk),
        .rst_n (reset),
        .d     (lrc),
        .pulse (tick)
    );

    assign addr_nx = {1'b0, addr} + (ADDR_W+1)'(1);

    // Address/length advance on the edge that closes a strobe, so addr
    // stays stable while the strobe is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st     <= IDLE;
            addr   <= '0;
            length <= '0;
            full   <= 1'b0;
            mem_wr <= 1'b0;
            mem_rd <= 1'b0;
        end else begin
            mem_wr <= 1'b0;
            mem_rd <= 1'b0;
            if (rec_p && st != RECORD) begin
                st     <= RECORD;
                addr   <= '0;
                length <= '0;
                full   <= 1'b0;
            end else begin
                case (st)
                    IDLE: begin
                        if (play_p && length != '0) begin
                            st   <= PLAY;
                            addr <= '0;
                        end
                    end
                    RECORD: begin
                        if (mem_wr) begin
                            addr   <= addr + ADDR_W'(1);
                            length <= length + (ADDR_W+1)'(1);
                            if (&addr) begin
                                full <= 1'b1;
                                st   <= IDLE;
                            end
                        end else if (tick && !rec_p) begin
                            mem_wr <= 1'b1;
                        end
                        if (rec_p) st <= IDLE;
                    end
                    PLAY: begin
                        if (mem_rd) begin
                            if (addr_nx == length) begin
                                addr <= '0;
                                st   <= IDLE;
                            end else begin
                                addr <= addr + ADDR_W'(1);
                            end
                        end else if (tick && !play_p) begin
                            mem_rd <= 1'b1;
                        end
                        if (play_p) st <= PAUSE;
                    end
                    PAUSE: begin
                        if (play_p) st <= PLAY;
                    end
                endcase
            end
        end
    end

    assign record = (st == RECORD);
    assign play   = (st == PLAY);
    assign state  = st;

endmodule

// File: tb/tb_rec_ctrl.sv
// Bench for rec_ctrl: cycle model with per-cycle compare plus
// directed scenarios with literal expectations.
module tb_rec_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          play_btn = 1'b0;
    logic          record_btn = 1'b0;
    logic          lrc = 1'b0;
    logic [AW-1:0] addr;
    logic [AW:0]   length;
    logic          record;
    logic          play;
    logic          mem_wr;
    logic          mem_rd;
    logic          full;
    logic [1:0]    state;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_q[$];
    int rd_q[$];

    rec_ctrl #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .play_btn   (play_btn),
        .record_btn (record_btn),
        .lrc        (lrc),
        .addr       (addr),
        .length     (length),
        .record     (record),
        .play       (play),
        .mem_wr     (mem_wr),
        .mem_rd     (mem_rd),
        .full       (full),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Model: inputs seen by the controller three edges after sampling.
    int       m_state;
    int       m_addr;
    int       m_len;
    bit       m_full;
    bit       m_wr;
    bit       m_rd;
    bit [3:0] hr;
    bit [3:0] hp;
    bit [3:0] hl;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state = 0; m_addr = 0; m_len = 0;
            m_full = 0; m_wr = 0; m_rd = 0;
            hr = '0; hp = '0; hl = '0;
        end else begin
            bit rp, pp, tk, done_w, done_r;
            rp = hr[2] & ~hr[3];
            pp = hp[2] & ~hp[3];
            tk = hl[2] & ~hl[3];
            done_w = m_wr;
            done_r = m_rd;
            m_wr = 0;
            m_rd = 0;
            if (m_state == 1) begin
                if (done_w) begin
                    m_len++;
                    m_addr = m_len % DEPTH;
                    if (m_len == DEPTH) begin
                        m_full = 1;
                        m_state = 0;
                    end
                end else if (tk && !rp) begin
                    m_wr = 1;
                end
                if (rp) m_state = 0;
            end else if (rp) begin
                m_state = 1; m_addr = 0; m_len = 0; m_full = 0;
            end else if (m_state == 0) begin
                if (pp && m_len > 0) begin
                    m_state = 2;
                    m_addr = 0;
                end
            end else if (m_state == 2) begin
                if (done_r) begin
                    m_addr++;
                    if (m_addr == m_len) begin
                        m_addr = 0;
                        m_state = 0;
                    end
                end else if (tk && !pp) begin
                    m_rd = 1;
                end
                if (pp) m_state = 3;
            end else if (pp) begin
                m_state = 2;
            end
            hr = {hr[2:0], record_btn};
            hp = {hp[2:0], play_btn};
            hl = {hl[2:0], lrc};
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_q(string name, bit rd, string exp);
        string s;
        s = "";
        if (rd) foreach (rd_q[i]) s = {s, $sformatf("%0d ", rd_q[i])};
        else    foreach (wr_q[i]) s = {s, $sformatf("%0d ", wr_q[i])};
        n_cmp++;
        if (s != exp) begin
            n_bad++;
            $display("FAIL %s: got [%s] expected [%s]", name, s, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("cyc_addr",   32'(addr),   32'(m_addr));
            check("cyc_length", 32'(length), 32'(m_len));
            check("cyc_state",  32'(state),  32'(m_state));
            check("cyc_record", 32'(record), 32'(m_state == 1));
            check("cyc_play",   32'(play),   32'(m_state == 2));
            check("cyc_mem_wr", 32'(mem_wr), 32'(m_wr));
            check("cyc_mem_rd", 32'(mem_rd), 32'(m_rd));
            check("cyc_full",   32'(full),   32'(m_full));
            if (mem_wr) wr_q.push_back(int'(addr));
            if (mem_rd) rd_q.push_back(int'(addr));
        end
    end

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_rec();
        record_btn = 1'b1; cycles(6);
        record_btn = 1'b0; cycles(6);
    endtask

    task automatic press_play();
        play_btn = 1'b1; cycles(6);
        play_btn = 1'b0; cycles(6);
    endtask

    task automatic lrc_rise();
        lrc = 1'b1; cycles(5);
        lrc = 1'b0; cycles(5);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; cycles(2);
        reset = 1'b1; cycles(2);
        wr_q.delete();
        rd_q.delete();
    endtask

    initial begin
        cycles(3);
        reset = 1'b1;
        cycles(2);
        check("reset_state",  32'(state),  0);
        check("reset_addr",   32'(addr),   0);
        check("reset_length", 32'(length), 0);

        // Record five samples then stop
        wr_q.delete();
        press_rec();
        check("rec_state", 32'(state), 1);
        check("rec_record", 32'(record), 1);
        repeat (5) lrc_rise();
        press_rec();
        chk_q("rec_addrs", 0, "0 1 2 3 4 ");
        check("rec_length", 32'(length), 5);
        check("rec_idle", 32'(state), 0);
        check("rec_off", 32'(record), 0);

        // Play to end, sixth lrc gives nothing
        rd_q.delete();
        press_play();
        check("play_on", 32'(play), 1);
        repeat (6) lrc_rise();
        chk_q("play_addrs", 1, "0 1 2 3 4 ");
        check("play_idle", 32'(state), 0);
        check("play_addr0", 32'(addr), 0);
        check("play_len_kept", 32'(length), 5);

        // Play with nothing recorded
        do_reset();
        press_play();
        check("empty_state", 32'(state), 0);
        check("empty_play", 32'(play), 0);
        chk_q("empty_rd", 1, "");
        chk_q("empty_wr", 0, "");

        // Pause and resume
        press_rec();
        repeat (5) lrc_rise();
        press_rec();
        check("pr_length", 32'(length), 5);
        rd_q.delete();
        press_play();
        repeat (2) lrc_rise();
        press_play();
        check("pr_paused", 32'(state), 3);
        repeat (3) lrc_rise();
        chk_q("pr_during", 1, "0 1 ");
        check("pr_hold", 32'(addr), 2);
        press_play();
        repeat (3) lrc_rise();
        chk_q("pr_all", 1, "0 1 2 3 4 ");
        check("pr_idle", 32'(state), 0);

        // Fill memory
        wr_q.delete();
        press_rec();
        repeat (17) lrc_rise();
        chk_q("full_addrs", 0,
              "0 1 2 3 4 5 6 7 8 9 10 11 12 13 14 15 ");
        check("full_flag", 32'(full), 1);
        check("full_length", 32'(length), 16);
        check("full_idle", 32'(state), 0);

        // Both buttons together: record wins
        do_reset();
        record_btn = 1'b1;
        play_btn = 1'b1;
        cycles(6);
        check("both_state", 32'(state), 1);
        check("both_play", 32'(play), 0);
        record_btn = 1'b0;
        play_btn = 1'b0;
        cycles(6);

        // Stop button coinciding with tick: no write
        wr_q.delete();
        lrc = 1'b1;
        record_btn = 1'b1;
        cycles(6);
        lrc = 1'b0;
        record_btn = 1'b0;
        cycles(6);
        chk_q("coinc_wr", 0, "");
        check("coinc_state", 32'(state), 0);
        check("coinc_length", 32'(length), 0);

        // Asynchronous reset in the middle of a recording
        press_rec();
        repeat (2) lrc_rise();
        check("mid_addr", 32'(addr), 2);
        check("mid_record", 32'(record), 1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_state",  32'(state),  0);
        check("ar_addr",   32'(addr),   0);
        check("ar_length", 32'(length), 0);
        check("ar_record", 32'(record), 0);
        check("ar_play",   32'(play),   0);
        check("ar_mem_wr", 32'(mem_wr), 0);
        check("ar_mem_rd", 32'(mem_rd), 0);
        check("ar_full",   32'(full),   0);
        cycles(2);
        reset = 1'b1;
        cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rec_ctrl.md
# rec_ctrl

Transport controller for the audio recorder. It sits between the debounced play/record buttons and the adc/dac/sram stages. It turns button presses into exclusive `record`/`play` enables, owns the shared 18-bit sample address counter, and issues one-cycle memory write/read strobes paced by the codec frame clock. It also remembers how long the last recording was, so playback stops at the end of valid data.

## Interface
- `ADDR_W`, default 18: sram address width.
- `clk`  in  1: system clock, 12 MHz from the pll.
- `reset`  in  1: asynchronous, active-low reset.
- `play_btn`  in  1: debounced play button level. Asynchronous to `clk`.
- `record_btn`  in  1: debounced record button level. Asynchronous to `clk`.
- `lrc`  in  1: codec frame clock (adclrc/daclrc). Asynchronous to `clk`.
- `addr`  out  ADDR_W: current sample address to sram.
- `length`  out  ADDR_W+1: number of valid recorded samples.
- `record`  out  1: record enable to adc/sram.
- `play`  out  1: play enable to dac/sram.
- `mem_wr`  out  1: one-cycle write strobe.
- `mem_rd`  out  1: one-cycle read strobe.
- `full`  out  1: the last recording filled all 2^ADDR_W locations.
- `state`  out  2: encoded FSM state, for debug.

## Operation
- **Input conditioning.**
  - `play_btn`, `record_btn` and `lrc` each pass through a 2-FF synchronizer.
  - Each synchronized signal then goes through a rising-edge detector, giving one-cycle pulses `play_p`, `rec_p` and `tick`.
- **States.** IDLE=0, RECORD=1, PLAY=2, PAUSE=3.
- **IDLE**
  - `rec_p` → RECORD. Sets `addr`=0, `length`=0, `full`=0.
  - `play_p` with `length`≠0 → PLAY. Sets `addr`=0.
  - `play_p` with `length`=0 is ignored.
- **RECORD**
  - On `tick`: `mem_wr`=1 for one cycle at the current `addr`. Then `addr`+1 and `length`+1.
  - If that write was at address 2^ADDR_W−1: `length`=2^ADDR_W, `full`=1, `addr`=0, → IDLE.
  - `rec_p` → IDLE (stop). `length` is retained.
  - `play_p` is ignored.
- **PLAY**
  - On `tick`: `mem_rd`=1 for one cycle at `addr`.
  - If `addr`+1 = `length`, then `addr`=0 and → IDLE. Otherwise `addr`+1.
  - `play_p` → PAUSE.
  - `rec_p` → RECORD, with the same initialization as from IDLE. This overwrites the old recording.
- **PAUSE**
  - `play_p` → PLAY, resuming at the held `addr`.
  - `rec_p` → RECORD, with the same initialization as from IDLE.
  - Ticks are ignored.
- **Output decode.** `record`=1 only in RECORD. `play`=1 only in PLAY. The two are never high together.
- **Simultaneous `rec_p` and `play_p`.** Record wins.
- **Button pulse and `tick` in the same cycle.** The state transition wins. No strobe is issued that cycle.
- **`addr` arithmetic.** Wraps modulo 2^ADDR_W. `length` is ADDR_W+1 bits, so it never wraps.

## Timing
- **Reset.** All outputs and state are reset asynchronously on `reset`=0:
  - state=IDLE, `addr`=0, `length`=0, `full`=0, `record`=0, `play`=0, `mem_wr`=0, `mem_rd`=0.
  - Reset mid-record discards `length`. This is the intended behavior.
- **`lrc` → strobe.** `lrc` rises before clk edge N. `tick` is high in the cycle after edge N+2. `mem_wr`/`mem_rd` are high in the following cycle, i.e. after edge N+3.
- **Address hold.** `addr` is stable during the strobe cycle. It updates on the clock edge that ends the strobe, so the next value appears one cycle after the strobe.
- **Button → state.** Button rises before edge N. `state`/`record`/`play` change after edge N+3. This is 2 sync + 1 edge-detect + 1 state register.
- **Strobes.** Exactly one clk cycle wide. At most one strobe per `lrc` period.
- **Throughput.** An `lrc` period of ≥ 8 clk cycles is guaranteed: 48 kHz frame rate vs 12 MHz clock.

## Structure
- **Package `rec_pkg`:**
  - state encoding constants IDLE/RECORD/PLAY/PAUSE;
  - default `ADDR_W`=18.
- **Sub-module `sync_edge`:** 2-FF synchronizer plus rising-edge pulse. Instantiated three times, for play, record and lrc.
- **Top of `rec_ctrl`:**
  - one FSM `always` block owning state, `addr`, `length` and `full`;
  - registered strobes;
  - combinational `record`/`play` decode.

## Test plan
- **Record then stop.** Reset; press record; 5 `lrc` rises; press record.
  - 5 `mem_wr` pulses at `addr` 0,1,2,3,4.
  - `length`=5, state=IDLE, `record`=0.
- **Playback to end.** Continue from the previous scenario; press play; 6 `lrc` rises.
  - `mem_rd` pulses at `addr` 0..4 only; after the 5th, state=IDLE and `addr`=0.
  - The 6th rise produces no strobe.
- **Play on empty.** Press play after reset.
  - State stays IDLE, `play`=0, no strobes.
- **Pause/resume.** `length`=5; play; 2 ticks; press play; 3 ticks; press play; 3 ticks.
  - Reads at addresses 0,1, then none during pause, then 2,3,4.
  - Ends in IDLE.
- **Full memory.** Use `ADDR_W`=4; record 17 ticks.
  - 16 writes at addresses 0..15; `full`=1, `length`=16, state=IDLE.
  - The 17th tick gives no strobe.
- **Priority and reset.**
  - Raise play and record in the same cycle from IDLE: state=RECORD.
  - Raise a button edge in the same cycle as `tick`: no strobe that cycle.
  - Assert `reset`=0 mid-record: all outputs go to 0 immediately, asynchronously.
